mem_req_queue: RTL and testbench



---
 rtl/mem_req_queue.sv | 147 ++++++++++++++
 tb/tb_mem_req_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - request FIFO feeding the memory controller Valid/RW/ready handshake
module mem_req_queue #(
  parameter int WIDTH   = 32,
  parameter int ADWIDTH = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_rw,
  input  logic [ADWIDTH-1:0]           req_addr,
  input  logic [WIDTH-1:0]             req_wdata,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic                         resp_rw,
  output logic [WIDTH-1:0]             resp_data,
  output logic                         resp_err,
  output logic                         mc_valid,
  output logic                         mc_rw,
  output logic [ADWIDTH-1:0]           mc_addr,
  output logic [WIDTH-1:0]             mc_wdata,
  input  logic [WIDTH-1:0]             mc_rdata,
  input  logic                         mc_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ERR, S_RELEASE} state_t;

  state_t              state, state_next;
  logic [TW-1:0]       timer;
  logic                timer_clr, timer_inc;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop;

  logic                fifo_rw    [DEPTH];
  logic [ADWIDTH-1:0]  fifo_addr  [DEPTH];
  logic [WIDTH-1:0]    fifo_wdata [DEPTH];

  assign req_ready = (count < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign busy      = (state != S_IDLE) || (count != '0);

  // mc_ready seen high in REQ is stale: only its fall marks acceptance
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_next = S_REQ;
          timer_clr  = 1'b1;
        end
      end
      S_REQ: begin
        if (!mc_ready) begin
          state_next = S_WAIT;
          timer_clr  = 1'b1;
        end else if (timer == T_LAST) begin
          state_next = S_ERR;
        end else begin
          timer_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (mc_ready) begin
          state_next = S_RELEASE;
        end else if (timer == T_LAST) begin
          state_next = S_ERR;
        end else begin
          timer_inc = 1'b1;
        end
      end
      S_ERR:     state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mc_valid    <= 1'b0;
      mc_rw       <= 1'b0;
      mc_addr     <= '0;
      mc_wdata    <= '0;
      resp_valid  <= 1'b0;
      resp_rw     <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (timer_clr) timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;

      if (push) begin
        fifo_rw[wr_ptr]    <= req_rw;
        fifo_addr[wr_ptr]  <= req_addr;
        fifo_wdata[wr_ptr] <= req_wdata;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) begin
        mc_rw    <= fifo_rw[rd_ptr];
        mc_addr  <= fifo_addr[rd_ptr];
        mc_wdata <= fifo_wdata[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // the request is withdrawn as soon as it completes or is aborted
      mc_valid <= (state_next == S_REQ) || (state_next == S_WAIT);

      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (state == S_WAIT && mc_ready) begin
        resp_valid <= 1'b1;
        resp_rw    <= mc_rw;
        resp_data  <= mc_rw ? mc_rdata : '0;
      end else if (state == S_ERR) begin
        resp_valid  <= 1'b1;
        resp_rw     <= mc_rw;
        resp_data   <= '0;
        resp_err    <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// tb/tb_mem_req_queue.sv - self-checking bench for mem_req_queue with a controller model
module tb_mem_req_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_rw;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid, resp_rw, resp_err;
  logic [31:0] resp_data;
  logic        mc_valid, mc_rw;
  logic [15:0] mc_addr;
  logic [31:0] mc_wdata, mc_rdata;
  logic        mc_ready;
  logic [2:0]  count;
  logic        busy, timeout_err;

  mem_req_queue #(.WIDTH(32), .ADWIDTH(16), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rw(resp_rw), .resp_data(resp_data), .resp_err(resp_err),
    .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_rdata(mc_rdata), .mc_ready(mc_ready),
    .count(count), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [31:0] data; logic err; } resp_t;
  typedef struct { logic rw; logic [15:0] addr; logic [31:0] wdata; } mreq_t;
  typedef struct { logic rw; logic [15:0] addr; logic [31:0] wdata; logic [31:0] exp_data; int exp_lat; } vec_t;

  resp_t exp_q[$];
  mreq_t mc_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    stall = 0;
  bit    hang = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdata_of(input logic [15:0] a);
    return (a == 16'h0020) ? 32'h12345678 : {~a, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives for one edge and returns at the following negedge.
  task automatic push_req(input logic rw, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee, output bit acc);
    resp_t r;
    mreq_t m;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    acc = req_ready;
    if (acc) begin
      r.rw = rw; r.data = ed; r.err = ee; exp_q.push_back(r);
      m.rw = rw; m.addr = a; m.wdata = d; mc_q.push_back(m);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
    end
    chk("drain_to_idle", ok, 1'b1);
  endtask

  // Controller: drops ready one cycle after valid, raises it two cycles later.
  initial begin
    int m_st, m_cnt;
    mc_ready = 1'b1; mc_rdata = '0; m_st = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_st = 0; mc_ready = 1'b1;
      end else if (m_st != 0 && !mc_valid) begin
        m_st = 0; mc_ready = 1'b1;
      end else begin
        case (m_st)
          0: if (mc_valid && !stall) m_st = 1;
          1: begin mc_ready = 1'b0; m_cnt = 1; m_st = 2; end
          2: if (!hang) begin
               if (m_cnt != 0) m_cnt--;
               else begin mc_ready = 1'b1; mc_rdata = rdata_of(mc_addr); m_st = 3; end
             end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard monitor on the response and controller sides.
  initial begin
    bit mv_q = 0;
    resp_t e;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (reset) mv_q = 0;
      else begin
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_resp: resp_valid=1 with no pending request");
          end else begin
            e = exp_q.pop_front();
            chk("resp_rw", resp_rw, e.rw);
            chk("resp_data", resp_data, e.data);
            chk("resp_err", resp_err, e.err);
            chk("release_mc_valid", mc_valid, 1'b0);
          end
        end
        if (mc_valid && !mv_q) begin
          if (mc_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_mc_valid: mc_valid rose with no pending request");
          end else begin
            m = mc_q.pop_front();
            chk("mc_rw", mc_rw, m.rw);
            chk("mc_addr", mc_addr, m.addr);
            if (!m.rw) chk("mc_wdata", mc_wdata, m.wdata);
          end
        end
        mv_q = mc_valid;
      end
    end
  end

  initial begin
    vec_t tbl[4];
    bit acc, got;
    int t0;
    int exp_cnt[6];

    tbl[0] = '{1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 5};
    tbl[1] = '{1'b1, 16'h0020, 32'h00000000, 32'h12345678, 5};
    tbl[2] = '{1'b1, 16'h0100, 32'h11111111, 32'hFEFF0100, 5};
    tbl[3] = '{1'b0, 16'hFFFF, 32'hFFFFFFFF, 32'h00000000, 5};
    exp_cnt = '{1, 1, 2, 3, 4, 4};

    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 3'd0);
    chk("rst_mc_valid", mc_valid, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      push_req(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp_data, 1'b0, acc);
      chk("vec_accept", acc, 1'b1);
      t0 = cyc; got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        if (resp_valid) got = 1;
      end
      chk("vec_resp_seen", got, 1'b1);
      chk("vec_latency", cyc - t0, tbl[i].exp_lat);
      wait_idle(20);
    end

    // Fill with the controller stalled; the sixth attempt meets a full queue.
    stall = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) stall = 0;
      push_req(i[0], 16'h0200 + 16'(i), 32'hA0000000 + i,
               i[0] ? rdata_of(16'h0200 + 16'(i)) : 32'h0, 1'b0, acc);
      chk("fill_accept", acc, (i < 5) ? 1'b1 : 1'b0);
      chk("fill_count", count, exp_cnt[i]);
    end
    chk("full_req_ready", req_ready, 1'b0);
    wait_idle(300);

    // Timeout on the first request; the queued one behind it completes.
    hang = 1;
    push_req(1'b1, 16'h0300, 32'h0, 32'h0, 1'b1, acc);
    t0 = cyc;
    push_req(1'b0, 16'h0304, 32'hCAFEF00D, 32'h0, 1'b0, acc);
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (resp_valid) got = 1;
      else @(negedge clk);
    end
    chk("err_resp_seen", got, 1'b1);
    chk("err_latency", cyc - t0, 12);
    chk("err_sticky_set", timeout_err, 1'b1);
    hang = 0;
    wait_idle(100);
    chk("err_sticky_hold", timeout_err, 1'b1);

    // Reset while waiting on the controller with two entries queued.
    hang = 1;
    push_req(1'b0, 16'h0400, 32'h1, 32'h0, 1'b0, acc);
    push_req(1'b0, 16'h0404, 32'h2, 32'h0, 1'b0, acc);
    push_req(1'b1, 16'h0408, 32'h3, 32'h0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("wait_count", count, 3'd2);
    chk("wait_mc_valid", mc_valid, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    mc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    hang = 0;
    chk("midrst_mc_valid", mc_valid, 1'b0);
    chk("midrst_count", count, 3'd0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_timeout_err", timeout_err, 1'b0);
    repeat (20) @(negedge clk);
    chk("post_rst_count", count, 3'd0);
    chk("post_rst_busy", busy, 1'b0);
    chk("sb_resp_left", exp_q.size(), 0);
    chk("sb_mc_left", mc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
